// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared-resource
// datapath: opcode and memory handshake in, control/mux strobes out.
// The master modport is the controller side; the slave modport is the datapath.
interface multicycle_controller_if #(
  parameter int STATE_W = 4,
  parameter int OP_W    = 6
);
  logic [OP_W-1:0]    opcode;
  logic               mem_ready;
  logic               mem_read;
  logic               mem_write;
  logic               i_or_d;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_src;
  logic               pc_write;
  logic               branch;
  logic               illegal_op;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_write,
           branch, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_write,
           branch, illegal_op, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared-memory, shared-ALU multicycle MIPS datapath
// (add/sub/and/or, lw, sw, beq). Control outputs are registered alongside the
// state; only the fetch strobes (gated by mem_ready) and illegal_op (decoded
// from the opcode in DECODE) are combinational.
// Optional feature: define MULTICYCLE_CONTROLLER_JUMP_EN to add the j
// instruction (opcode 000010, JUMP state 9). Without it, 000010 is illegal.
module multicycle_controller #(
  parameter int STATE_W = 4,
  parameter int OP_W    = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_controller_if.master  bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXEC   = STATE_W'(6),
    ALUWB  = STATE_W'(7),
    BRANCH = STATE_W'(8),
    JUMP   = STATE_W'(9)
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
`ifdef MULTICYCLE_CONTROLLER_JUMP_EN
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`endif

  // Registered state and state-decoded outputs
  state_t     r_state;
  logic       r_fetch;      // in FETCH with the instruction request active
  logic       r_mem_read;
  logic       r_mem_write;
  logic       r_i_or_d;
  logic       r_reg_dst;
  logic       r_mem_to_reg;
  logic       r_reg_write;
  logic       r_alu_src_a;
  logic [1:0] r_alu_src_b;
  logic [1:0] r_alu_op;
  logic [1:0] r_pc_src;
  logic       r_pc_write;   // unconditional PC load outside FETCH (jump)
  logic       r_branch;

  // Next-state and the output values that go with it
  state_t     w_next_state;
  logic       w_fetch;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_i_or_d;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_pc_src;
  logic       w_pc_write;
  logic       w_branch;
  logic       w_op_legal;

  // Opcode classification used by DECODE
  always_comb begin
    w_op_legal = 1'b0;
    if (bus.opcode == OP_RTYPE || bus.opcode == OP_LW ||
        bus.opcode == OP_SW    || bus.opcode == OP_BEQ) begin
      w_op_legal = 1'b1;
    end
`ifdef MULTICYCLE_CONTROLLER_JUMP_EN
    if (bus.opcode == OP_J) begin
      w_op_legal = 1'b1;
    end
`endif
  end

  // Next-state logic; FETCH only advances once its request has actually been
  // presented, so the cycle right after reset release issues the first fetch.
  always_comb begin
    w_next_state = FETCH;
    case (r_state)
      FETCH:  w_next_state = (r_fetch && bus.mem_ready) ? DECODE : FETCH;
      DECODE: begin
        if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
          w_next_state = MEMADR;
        end else if (bus.opcode == OP_RTYPE) begin
          w_next_state = EXEC;
        end else if (bus.opcode == OP_BEQ) begin
          w_next_state = BRANCH;
`ifdef MULTICYCLE_CONTROLLER_JUMP_EN
        end else if (bus.opcode == OP_J) begin
          w_next_state = JUMP;
`endif
        end else begin
          w_next_state = FETCH;
        end
      end
      MEMADR: begin
        if (bus.opcode == OP_LW) begin
          w_next_state = MEMRD;
        end else if (bus.opcode == OP_SW) begin
          w_next_state = MEMWR;
        end else begin
          w_next_state = FETCH;
        end
      end
      MEMRD:  w_next_state = bus.mem_ready ? MEMWB : MEMRD;
      MEMWB:  w_next_state = FETCH;
      MEMWR:  w_next_state = bus.mem_ready ? FETCH : MEMWR;
      EXEC:   w_next_state = ALUWB;
      ALUWB:  w_next_state = FETCH;
      BRANCH: w_next_state = FETCH;
`ifdef MULTICYCLE_CONTROLLER_JUMP_EN
      JUMP:   w_next_state = FETCH;
`endif
      default: w_next_state = FETCH;
    endcase
  end

  // Moore output decode of the state being entered, so outputs are registered
  always_comb begin
    w_fetch      = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_i_or_d     = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_pc_src     = 2'b00;
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    case (w_next_state)
      FETCH: begin
        w_fetch     = 1'b1;
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
      end
      DECODE: begin
        w_alu_src_b = 2'b11;
      end
      MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      MEMRD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
      end
      MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      MEMWR: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
      end
      EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      ALUWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b01;
        w_pc_src    = 2'b01;
        w_branch    = 1'b1;
      end
`ifdef MULTICYCLE_CONTROLLER_JUMP_EN
      JUMP: begin
        w_pc_write = 1'b1;
        w_pc_src   = 2'b10;
      end
`endif
      default: begin
        w_fetch = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces all strobes low and FETCH selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_fetch      <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_i_or_d     <= 1'b0;
      r_reg_dst    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_alu_src_a  <= 1'b0;
      r_alu_src_b  <= 2'b01;
      r_alu_op     <= 2'b00;
      r_pc_src     <= 2'b00;
      r_pc_write   <= 1'b0;
      r_branch     <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_fetch      <= w_fetch;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_i_or_d     <= w_i_or_d;
      r_reg_dst    <= w_reg_dst;
      r_mem_to_reg <= w_mem_to_reg;
      r_reg_write  <= w_reg_write;
      r_alu_src_a  <= w_alu_src_a;
      r_alu_src_b  <= w_alu_src_b;
      r_alu_op     <= w_alu_op;
      r_pc_src     <= w_pc_src;
      r_pc_write   <= w_pc_write;
      r_branch     <= w_branch;
    end
  end

  // Instruction load and PC increment both complete with the memory access
  assign bus.ir_write   = r_fetch & bus.mem_ready;
  assign bus.pc_write   = (r_fetch & bus.mem_ready) | r_pc_write;
  assign bus.illegal_op = (r_state == DECODE) & ~w_op_legal;

  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;
  assign bus.i_or_d     = r_i_or_d;
  assign bus.reg_dst    = r_reg_dst;
  assign bus.mem_to_reg = r_mem_to_reg;
  assign bus.reg_write  = r_reg_write;
  assign bus.alu_src_a  = r_alu_src_a;
  assign bus.alu_src_b  = r_alu_src_b;
  assign bus.alu_op     = r_alu_op;
  assign bus.pc_src     = r_pc_src;
  assign bus.branch     = r_branch;
  assign bus.state      = r_state;

endmodule
